aexm_ifetch_resp: RTL and testbench
===================================

// Module: aexm_ifetch_resp
// PURPOSE
// Instruction-side responder to the BPCU fetch address (aexm_icache_precycle_addr).
// Direct-mapped I-cache front end. Samples the precycle address on every enabled cycle and returns the instruction word next cycle on a hit.
// On a miss it stalls the core and burst-fills one line from backing memory.
// PARAMETERS
// LINE_WORDS  4   32-bit words per line (power of 2, >=2)
// LINES       64  number of lines (power of 2)
// PORTS
// gclk           in   1   clock
// grst           in   1   reset, synchronous, active-high
// x_en           in   1   core pipeline enable; address sampled when high
// precycle_addr  in   32  fetch byte address from BPCU; [1:0] ignored
// inv            in   1   pulse: invalidate whole cache
// ic_rdy         out  1   0 = core must hold x_en low (stall)
// ic_inst        out  32  instruction for last sampled address; valid when ic_rdy=1
// mem_req        out  1   line-fill request, held for whole burst
// mem_addr       out  30  word address of line base ([31:2]; low log2(LINE_WORDS) bits zero)
// mem_ack        in   1   one word delivered on mem_data this cycle
// mem_data       in   32  fill data, words in ascending order
// BEHAVIOUR
// - Addr split: off=[OB+1:2], idx=[IB+OB+1:OB+2], tag=rest to [31]; OB=log2(LINE_WORDS), IB=log2(LINES).
// - Reset: ic_rdy=0, mem_req=0, mem_addr=0, ic_inst=0, FSM->CLEAR, idx ctr=0.
// - CLEAR: one valid bit cleared per cycle; ic_rdy=0; exits to IDLE after LINES cycles.
// - Hit path: addr A sampled at edge N (x_en=1).
//   - Tag/data RAM read is synchronous; compare in cycle N+1.
//   - Hit: ic_inst=word(A), ic_rdy=1 in N+1.
// - Miss in N+1: ic_rdy=0 same cycle (combinational from compare) -> FILL.
//   - mem_addr latched to line base of A.
// - FILL: mem_req=1; each mem_ack writes mem_data to word ctr, then ctr++.
//   - On last ack: write tag and set valid; mem_req drops next cycle -> REPLAY.
// - REPLAY: re-read RAM at held A (x_en held low by core) -> IDLE.
//   - Result compares as hit: ic_rdy=1, ic_inst=word(A).
//   - Miss latency: LINE_WORDS acks + 2 cycles.
// - x_en=0 in IDLE: no new sample; ic_inst/ic_rdy hold last value.
// - inv in IDLE: -> CLEAR next cycle, ic_rdy=0.
// - inv during FILL/REPLAY: latched as pending; FILL completes, then CLEAR instead of REPLAY.
//   - The CLEAR is then followed by a re-lookup (miss, refill).
// - mem_ack outside FILL: ignored. mem_req never drops mid-burst except on grst.
// - grst mid-FILL: burst abandoned, mem_req=0 next edge, partial line stays invalid (CLEAR).
// - Counters wrap mod LINE_WORDS / LINES; no other arithmetic.
// - Address sampling and FSM advance on gclk only; no x_en gating of FILL/CLEAR.
// STRUCTURE
// - Package aexm_icache_pkg: FSM enum {CLEAR, IDLE, FILL, REPLAY}, OB/IB/TAG_W localparams, addr-field functions.
// - Sub-module aexm_ifetch_tagram: LINES x (valid+tag) array.
//   - Synchronous read, write port, per-line valid clear.
//   - Data array is a plain inferred RAM in the top level.
// TESTING
// - Reset: grst 1 cycle -> ic_rdy=0 for 64 cycles, then 1; mem_req stays 0.
// - Cold miss at 0x0000_0100 -> mem_req=1, mem_addr=0x40.
//   - 4 acks of 0xA0..0xA3 -> ic_rdy=1 two cycles after last ack.
//   - ic_inst=0xA0.
// - Hit after fill: addrs 0x104, 0x108, 0x10C, one per cycle with x_en=1.
//   - ic_inst=0xA1, 0xA2, 0xA3 each next cycle; ic_rdy stays 1; no mem_req.
// - Conflict: 0x0000_0500 (same idx, new tag) -> miss and refill with 0xB0..0xB3.
//   - Then 0x100 misses again.
// - inv pulsed in 2nd FILL ack cycle: burst finishes (4 acks), CLEAR runs 64 cycles.
//   - Re-fetch of same addr misses.
// - grst asserted after 2 acks -> mem_req=0 next edge.
//   - After CLEAR, fetch of that line misses; late acks ignored.

Source files
------------

// File: rtl/aexm_icache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
package aexm_icache_pkg;

    typedef enum logic [1:0] {
        StClear,
        StIdle,
        StFill,
        StReplay
    } ic_state_e;

    localparam int unsigned LINE_WORDS_DEF = 4;
    localparam int unsigned LINES_DEF      = 64;
    localparam int unsigned OB             = $clog2(LINE_WORDS_DEF);
    localparam int unsigned IB             = $clog2(LINES_DEF);
    localparam int unsigned TAG_W          = 30 - OB - IB;

    // Extracts addr[lsb +: width] from a byte address.
    function automatic logic [31:0] addr_field(input logic [31:0] addr,
                                               input int unsigned lsb,
                                               input int unsigned width);
        logic [31:0] mask;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (addr >> lsb) & mask;
    endfunction

endpackage

// File: rtl/aexm_ifetch_tagram.sv
// Tag store for the instruction cache: per-line valid flops plus a tag RAM,
// synchronous read, one write port and a per-line valid clear.
module aexm_ifetch_tagram
    import aexm_icache_pkg::*;
#(
    parameter int unsigned LINES = LINES_DEF,
    parameter int unsigned TAG_W = aexm_icache_pkg::TAG_W
) (
    input  logic                     gclk,
    input  logic                     rd_en_i,
    input  logic [$clog2(LINES)-1:0] rd_idx_i,
    output logic                     rd_valid_o,
    output logic [TAG_W-1:0]         rd_tag_o,
    input  logic                     wr_en_i,
    input  logic [$clog2(LINES)-1:0] wr_idx_i,
    input  logic [TAG_W-1:0]         wr_tag_i,
    input  logic                     clr_en_i,
    input  logic [$clog2(LINES)-1:0] clr_idx_i
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_ram [LINES];

    // Valid bits have no reset; the controller sweeps them clear after grst.
    always_ff @(posedge gclk) begin
        if (clr_en_i) begin
            valid_q[clr_idx_i] <= 1'b0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
        if (rd_en_i) begin
            rd_valid_o <= valid_q[rd_idx_i];
        end
    end

    always_ff @(posedge gclk) begin
        if (wr_en_i) begin
            tag_ram[wr_idx_i] <= wr_tag_i;
        end
        if (rd_en_i) begin
            rd_tag_o <= tag_ram[rd_idx_i];
        end
    end

endmodule

// File: rtl/aexm_ifetch_resp.sv
// Direct-mapped I-cache front end answering the BPCU precycle fetch address:
// one-cycle hit path, stall plus burst line fill on miss, whole-cache invalidate.
module aexm_ifetch_resp
    import aexm_icache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
    parameter int unsigned LINES      = LINES_DEF
) (
    input  logic        gclk,
    input  logic        grst,
    input  logic        x_en,
    input  logic [31:0] precycle_addr,
    input  logic        inv,
    output logic        ic_rdy,
    output logic [31:0] ic_inst,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data
);

    localparam int unsigned OffW  = $clog2(LINE_WORDS);
    localparam int unsigned IdxW  = $clog2(LINES);
    localparam int unsigned TagW  = 30 - OffW - IdxW;
    localparam int unsigned WordW = OffW + IdxW;

    ic_state_e        state_q;
    logic [29:0]      a_q;
    logic             lookup_q;
    logic             rdy_q;
    logic             relook_q;
    logic             inv_pend_q;
    logic             mem_req_q;
    logic [29:0]      mem_addr_q;
    logic [OffW-1:0]  fill_ctr_q;
    logic [IdxW-1:0]  clr_idx_q;
    logic [31:0]      data_q;
    logic [31:0]      data_ram [LINES*LINE_WORDS];

    logic [OffW-1:0]  a_off, pre_off, rd_off;
    logic [IdxW-1:0]  a_idx, pre_idx, rd_idx;
    logic [TagW-1:0]  a_tag, tag_rd;
    logic             tag_vld, hit, miss, take, sample, rd_en, fill_wr, last_ack;
    logic             unused_byte_bits;

    assign unused_byte_bits = ^precycle_addr[1:0];

    assign a_off   = OffW'(addr_field({a_q, 2'b00}, 2, OffW));
    assign a_idx   = IdxW'(addr_field({a_q, 2'b00}, OffW + 2, IdxW));
    assign a_tag   = TagW'(addr_field({a_q, 2'b00}, WordW + 2, TagW));
    assign pre_off = OffW'(addr_field(precycle_addr, 2, OffW));
    assign pre_idx = IdxW'(addr_field(precycle_addr, OffW + 2, IdxW));

    assign hit  = tag_vld && (tag_rd == a_tag);
    assign miss = (state_q == StIdle) && lookup_q && !hit;
    // A new fetch is accepted only while the previous one did not miss.
    assign take   = (state_q == StIdle) && x_en && !miss;
    assign sample = take && !inv;
    assign rd_en  = sample || ((state_q == StReplay) && !inv);
    assign rd_idx = sample ? pre_idx : a_idx;
    assign rd_off = sample ? pre_off : a_off;

    assign fill_wr  = (state_q == StFill) && mem_ack && !grst;
    assign last_ack = fill_wr && (fill_ctr_q == OffW'(LINE_WORDS - 1));

    assign ic_rdy   = (state_q == StIdle) && (lookup_q ? hit : rdy_q);
    assign ic_inst  = data_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

    aexm_ifetch_tagram #(
        .LINES (LINES),
        .TAG_W (TagW)
    ) u_tagram (
        .gclk       (gclk),
        .rd_en_i    (rd_en),
        .rd_idx_i   (rd_idx),
        .rd_valid_o (tag_vld),
        .rd_tag_o   (tag_rd),
        .wr_en_i    (last_ack),
        .wr_idx_i   (a_idx),
        .wr_tag_i   (a_tag),
        .clr_en_i   (state_q == StClear),
        .clr_idx_i  (clr_idx_q)
    );

    always_ff @(posedge gclk) begin
        if (fill_wr) begin
            data_ram[{a_idx, fill_ctr_q}] <= mem_data;
        end
    end

    always_ff @(posedge gclk) begin
        if (grst) begin
            data_q <= '0;
        end else if (rd_en) begin
            data_q <= data_ram[{rd_idx, rd_off}];
        end
    end

    always_ff @(posedge gclk) begin
        if (grst) begin
            state_q    <= StClear;
            a_q        <= '0;
            lookup_q   <= 1'b0;
            rdy_q      <= 1'b0;
            relook_q   <= 1'b0;
            inv_pend_q <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            fill_ctr_q <= '0;
            clr_idx_q  <= '0;
        end else begin
            lookup_q <= rd_en;
            if (take) begin
                a_q <= precycle_addr[31:2];
            end
            unique case (state_q)
                StClear: begin
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == IdxW'(LINES - 1)) begin
                        relook_q <= 1'b0;
                        if (relook_q) begin
                            state_q <= StReplay;
                        end else begin
                            state_q <= StIdle;
                            rdy_q   <= 1'b1;
                        end
                    end
                end
                StIdle: begin
                    if (lookup_q) begin
                        rdy_q <= hit;
                    end
                    // An outstanding or just-accepted fetch is retried once the sweep ends.
                    if (inv) begin
                        state_q  <= StClear;
                        relook_q <= take || miss;
                    end else if (miss) begin
                        state_q    <= StFill;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {a_q[29:OffW], {OffW{1'b0}}};
                        fill_ctr_q <= '0;
                        inv_pend_q <= 1'b0;
                    end
                end
                StFill: begin
                    if (inv) begin
                        inv_pend_q <= 1'b1;
                    end
                    if (fill_wr) begin
                        fill_ctr_q <= fill_ctr_q + 1'b1;
                    end
                    if (last_ack) begin
                        mem_req_q  <= 1'b0;
                        inv_pend_q <= 1'b0;
                        if (inv || inv_pend_q) begin
                            state_q  <= StClear;
                            relook_q <= 1'b1;
                        end else begin
                            state_q <= StReplay;
                        end
                    end
                end
                StReplay: begin
                    if (inv) begin
                        state_q  <= StClear;
                        relook_q <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StClear;
            endcase
        end
    end

endmodule

// File: tb/tb_aexm_ifetch_resp.sv
// Randomised bench for aexm_ifetch_resp: a line-residency model and a backing
// memory predict hit/miss, fill address, latency and returned instruction.
module tb_aexm_ifetch_resp;

    logic        gclk = 1'b0;
    logic        grst = 1'b1;
    logic        x_en = 1'b0;
    logic        inv = 1'b0;
    logic        mem_ack = 1'b0;
    logic [31:0] precycle_addr = '0;
    logic [31:0] mem_data = '0;
    logic        ic_rdy;
    logic        mem_req;
    logic [31:0] ic_inst;
    logic [29:0] mem_addr;

    aexm_ifetch_resp dut (
        .gclk          (gclk),
        .grst          (grst),
        .x_en          (x_en),
        .precycle_addr (precycle_addr),
        .inv           (inv),
        .ic_rdy        (ic_rdy),
        .ic_inst       (ic_inst),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_data      (mem_data)
    );

    always #5 gclk = ~gclk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge gclk) cyc++;

    // Responder controls and observations.
    int beat         = 0;
    int ack_limit    = 1000;
    int inv_beat     = 0;
    int last_ack_cyc = 0;
    bit spurious     = 1'b0;
    bit inv_pulse    = 1'b0;

    logic [31:0] bm [logic [29:0]];
    int resident [64];

    function automatic logic [31:0] bmem_rd(input logic [29:0] wa);
        if (bm.exists(wa)) return bm[wa];
        return ({2'b00, wa} * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < 64; i++) resident[i] = -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Backing memory: acks with random gaps, optional inv on a chosen beat.
    initial begin
        forever begin
            @(posedge gclk);
            #1;
            mem_ack  = 1'b0;
            mem_data = '0;
            inv      = 1'b0;
            if (inv_pulse) begin
                inv       = 1'b1;
                inv_pulse = 1'b0;
            end
            if (spurious) begin
                mem_ack  = 1'b1;
                mem_data = $urandom;
            end else if (mem_req && beat < ack_limit && $urandom_range(0, 3) != 0) begin
                mem_ack  = 1'b1;
                mem_data = bmem_rd(mem_addr + 30'(beat));
                beat++;
                if (beat == inv_beat) begin
                    inv      = 1'b1;
                    inv_beat = 0;
                end
                if (beat == 4) begin
                    beat         = 0;
                    last_ack_cyc = cyc;
                end
            end
        end
    end

    task automatic do_reset(input bit spur);
        int lows;
        int reqs;
        @(negedge gclk);
        grst      = 1'b1;
        beat      = 0;
        ack_limit = 1000;
        @(negedge gclk);
        grst = 1'b0;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_inst", ic_inst, 32'd0);
        spurious = spur;
        lows = 0;
        reqs = 0;
        for (int i = 0; i < 200 && !ic_rdy; i++) begin
            lows++;
            if (mem_req) reqs++;
            if (i == 8) spurious = 1'b0;
            @(negedge gclk);
        end
        spurious = 1'b0;
        check("rst_clear_len", lows, 32'd64);
        check("rst_no_req", reqs, 32'd0);
        clear_model();
    endtask

    task automatic inv_idle();
        int lows;
        int reqs;
        inv_pulse = 1'b1;
        @(negedge gclk);
        lows = 0;
        reqs = 0;
        @(negedge gclk);
        for (int i = 0; i < 200 && !ic_rdy; i++) begin
            lows++;
            if (mem_req) reqs++;
            @(negedge gclk);
        end
        check("inv_clear_len", lows, 32'd64);
        check("inv_no_req", reqs, 32'd0);
        clear_model();
    endtask

    task automatic fetch(input logic [31:0] addr, input int inv_at);
        int  idx, line, rises;
        bit  exp_hit, prev_req;
        idx     = int'(addr[9:4]);
        line    = int'(addr[31:4]);
        exp_hit = (resident[idx] == line);
        inv_beat = exp_hit ? 0 : inv_at;
        x_en = 1'b1;
        precycle_addr = addr;
        @(posedge gclk);
        #1;
        x_en = 1'b0;
        precycle_addr = $urandom;
        @(negedge gclk);
        check("lookup_rdy", 32'(ic_rdy), 32'(exp_hit));
        if (exp_hit) begin
            check("hit_no_req", 32'(mem_req), 32'd0);
        end else begin
            @(negedge gclk);
            check("fill_req", 32'(mem_req), 32'd1);
            check("fill_addr", 32'(mem_addr), {2'b00, addr[31:4], 2'b00});
            rises    = 1;
            prev_req = 1'b1;
            for (int i = 0; i < 400 && !ic_rdy; i++) begin
                @(negedge gclk);
                if (mem_req && !prev_req) begin
                    rises++;
                    check("clear_gap", 32'((cyc - last_ack_cyc) >= 65), 32'd1);
                end
                prev_req = mem_req;
            end
            check("fill_done", 32'(ic_rdy), 32'd1);
            check("bursts", rises, (inv_at != 0) ? 32'd2 : 32'd1);
            check("miss_latency", cyc - last_ack_cyc, 32'd2);
            if (inv_at != 0) clear_model();
            resident[idx] = line;
        end
        check("inst", ic_inst, bmem_rd(addr[31:2]));
        inv_beat = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        int r;
        clear_model();
        for (int i = 0; i < 4; i++) begin
            bm[30'h40 + 30'(i)]  = 32'hA0 + 32'(i);
            bm[30'h140 + 30'(i)] = 32'hB0 + 32'(i);
        end

        do_reset(1'b0);

        fetch(32'h0000_0100, 0);
        check("cold_inst_a0", ic_inst, 32'hA0);
        fetch(32'h0000_0104, 0);
        fetch(32'h0000_0108, 0);
        fetch(32'h0000_010C, 0);
        check("hit_inst_a3", ic_inst, 32'hA3);
        for (int i = 0; i < 3; i++) begin
            @(negedge gclk);
            check("hold_rdy", 32'(ic_rdy), 32'd1);
            check("hold_inst", ic_inst, 32'hA3);
        end

        fetch(32'h0000_0500, 0);
        check("conflict_inst_b0", ic_inst, 32'hB0);
        fetch(32'h0000_0100, 0);

        inv_idle();
        fetch(32'h0000_0104, 0);

        fetch(32'h0000_0208, 2);
        fetch(32'h0000_0208, 0);

        // grst after two beats of a burst, with stray acks during the sweep.
        ack_limit = 2;
        x_en = 1'b1;
        precycle_addr = 32'h0000_0304;
        @(posedge gclk);
        #1;
        x_en = 1'b0;
        for (int i = 0; i < 100 && beat < 2; i++) @(negedge gclk);
        check("two_acks", beat, 32'd2);
        @(negedge gclk);
        do_reset(1'b1);
        fetch(32'h0000_0304, 0);
        fetch(32'h0000_0300, 0);

        for (int i = 0; i < 250; i++) begin
            a = ((32'($urandom_range(0, 2)) * 32'h1357_0C00) & 32'hFFFF_FC00)
              | (32'($urandom_range(0, 7)) << 4)
              | 32'($urandom_range(0, 15));
            r = $urandom_range(0, 99);
            if (r < 3) inv_idle();
            else fetch(a, (r < 12) ? $urandom_range(1, 4) : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
